pktunit_axis_joiner: RTL and testbench

- Receive-side end of the three-channel pktunit stream (data / flags / eop, each with independent valid/ready), i.e. the consumer of what the socket feeder produces.
- Joins the three channels into a single registered AXI4-Stream master (tdata/tkeep/tlast/tuser) for synthesizable packet-processing logic.
- Keeps packet and byte statistics and flags protocol violations.

---
 rtl/pktunit_axis_joiner.sv | 240 ++++++++++++++++++++++++
 tb/tb_pktunit_axis_joiner.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pktunit_axis_joiner.sv
// pktunit_axis_joiner: joins the pktunit data / flags / eop channels into a
// registered AXI4-Stream master behind a 2-entry skid buffer. It also keeps
// packet/byte statistics and raises a sticky protocol-error flag.
// Optional feature macro: PKTUNIT_DROP_ERR_EN drops packets whose SOP flags
// carry rx error (bit0) and counts them on drop_cnt.
module pktunit_axis_joiner #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_BYTES*8-1:0] data_d,
  input  logic                    data_v,
  output logic                    data_r,
  input  logic [7:0]              flags_d,
  input  logic                    flags_v,
  output logic                    flags_r,
  input  logic [7:0]              eop_d,
  input  logic                    eop_v,
  output logic                    eop_r,
  output logic [DATA_BYTES*8-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [7:0]              m_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        byte_cnt,
`ifdef PKTUNIT_DROP_ERR_EN
  output logic [CNT_W-1:0]        drop_cnt,
`endif
  output logic                    proto_err
);

  localparam int unsigned DATA_W = DATA_BYTES * 8;
  localparam logic [7:0]  DB8    = 8'(DATA_BYTES);
`ifdef PKTUNIT_DROP_ERR_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_MID  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [7:0] tuser_q, tuser_d;

  logic                  join_c, push_c, pop_c, space_c;
  logic                  last_c, eop_big_c;
  logic [7:0]            eop_eff_c;
  logic [DATA_BYTES-1:0] keep_c;
  logic [7:0]            user_c;
  logic [CNT_W-1:0]      pop_bytes_c;

  logic                  out_v_q, skid_v_q;
  logic [DATA_W-1:0]     out_data_q, skid_data_q;
  logic [DATA_BYTES-1:0] out_keep_q, skid_keep_q;
  logic                  out_last_q, skid_last_q;
  logic [7:0]            out_user_q, skid_user_q;

  logic [CNT_W-1:0]      pkt_cnt_q, byte_cnt_q;
  logic                  proto_err_q;

  // Output handshake and skid space (space counts this cycle's pop)
  assign pop_c   = out_v_q & m_tready;
  assign space_c = ~skid_v_q | pop_c;

  // Decode eop into tlast / tkeep, clamping oversize counts to a full beat
  always_comb begin
    keep_c    = '0;
    last_c    = (eop_d != 8'd0);
    eop_big_c = (eop_d > DB8);
    eop_eff_c = eop_big_c ? DB8 : eop_d;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_c[i] = ~last_c | (8'(i) < eop_eff_c);
    end
  end

  // Join FSM: next state, join decision and flags ready
  always_comb begin
    state_d = state_q;
    tuser_d = tuser_q;
    user_c  = tuser_q;
    join_c  = 1'b0;
    push_c  = 1'b0;
    flags_r = 1'b0;
    case (state_q)
      ST_SOP: begin
        user_c = flags_d;
        if (rst_n && data_v && eop_v && flags_v &&
            (space_c || (DROP_EN && flags_d[0]))) begin
          join_c  = 1'b1;
          flags_r = 1'b1;
          tuser_d = flags_d;
          if (DROP_EN && flags_d[0]) begin
            state_d = last_c ? ST_SOP : ST_DROP;
          end else begin
            push_c  = 1'b1;
            state_d = last_c ? ST_SOP : ST_MID;
          end
        end
      end
      ST_MID: begin
        if (rst_n && data_v && eop_v && space_c) begin
          join_c = 1'b1;
          push_c = 1'b1;
          if (last_c) state_d = ST_SOP;
        end
      end
      ST_DROP: begin
        if (rst_n && data_v && eop_v) begin
          join_c = 1'b1;
          if (last_c) state_d = ST_SOP;
        end
      end
      default: state_d = ST_SOP;
    endcase
  end

  assign data_r = join_c;
  assign eop_r  = join_c;

  // FSM state and per-packet tuser holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SOP;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      tuser_q <= tuser_d;
    end
  end

  // Two-entry output buffer: out_* drives the bus, skid_* catches one extra beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= '0;
    end else if (out_v_q) begin
      if (pop_c) begin
        if (skid_v_q) begin
          out_data_q <= skid_data_q;
          out_keep_q <= skid_keep_q;
          out_last_q <= skid_last_q;
          out_user_q <= skid_user_q;
          skid_v_q   <= push_c;
          if (push_c) begin
            skid_data_q <= data_d;
            skid_keep_q <= keep_c;
            skid_last_q <= last_c;
            skid_user_q <= user_c;
          end
        end else if (push_c) begin
          out_data_q <= data_d;
          out_keep_q <= keep_c;
          out_last_q <= last_c;
          out_user_q <= user_c;
        end else begin
          out_v_q <= 1'b0;
        end
      end else if (push_c) begin
        skid_v_q    <= 1'b1;
        skid_data_q <= data_d;
        skid_keep_q <= keep_c;
        skid_last_q <= last_c;
        skid_user_q <= user_c;
      end
    end else if (push_c) begin
      out_v_q    <= 1'b1;
      out_data_q <= data_d;
      out_keep_q <= keep_c;
      out_last_q <= last_c;
      out_user_q <= user_c;
    end
  end

  // Number of valid bytes in the beat leaving this cycle
  always_comb begin
    pop_bytes_c = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      pop_bytes_c = pop_bytes_c + CNT_W'(out_keep_q[i]);
    end
  end

  // Statistics on output handshakes and sticky protocol error on joins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (pop_c) begin
        pkt_cnt_q  <= pkt_cnt_q + CNT_W'(out_last_q);
        byte_cnt_q <= byte_cnt_q + pop_bytes_c;
      end
      if (join_c && eop_big_c) proto_err_q <= 1'b1;
    end
  end

`ifdef PKTUNIT_DROP_ERR_EN
  logic [CNT_W-1:0] drop_cnt_q;
  logic             drop_inc_c;

  assign drop_inc_c = join_c && last_c &&
                      ((state_q == ST_DROP) || ((state_q == ST_SOP) && flags_d[0]));

  // Dropped packets counted on their last consumed beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_inc_c) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign m_tvalid  = out_v_q;
  assign m_tdata   = out_data_q;
  assign m_tkeep   = out_keep_q;
  assign m_tlast   = out_last_q;
  assign m_tuser   = out_user_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign byte_cnt  = byte_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_pktunit_axis_joiner.sv
// Scoreboard bench for pktunit_axis_joiner: per-channel random drivers, a
// packet-level reference model feeding an expected-beat queue, and a monitor
// that pops and compares on every output handshake.
module tb_pktunit_axis_joiner;

  localparam int unsigned DB = 8;
  localparam int unsigned DW = DB * 8;
  localparam int unsigned CW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
    logic [7:0]    user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_d;
  logic          data_v;
  logic          data_r;
  logic [7:0]    flags_d;
  logic          flags_v;
  logic          flags_r;
  logic [7:0]    eop_d;
  logic          eop_v;
  logic          eop_r;
  logic [DW-1:0] m_tdata;
  logic [DB-1:0] m_tkeep;
  logic          m_tlast;
  logic [7:0]    m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] byte_cnt;
  logic          proto_err;
`ifdef PKTUNIT_DROP_ERR_EN
  logic [CW-1:0] drop_cnt;
`endif

  pktunit_axis_joiner #(.DATA_BYTES(DB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_d    (data_d),
    .data_v    (data_v),
    .data_r    (data_r),
    .flags_d   (flags_d),
    .flags_v   (flags_v),
    .flags_r   (flags_r),
    .eop_d     (eop_d),
    .eop_v     (eop_v),
    .eop_r     (eop_r),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .pkt_cnt   (pkt_cnt),
    .byte_cnt  (byte_cnt),
`ifdef PKTUNIT_DROP_ERR_EN
    .drop_cnt  (drop_cnt),
`endif
    .proto_err (proto_err)
  );

  initial forever #5 clk = ~clk;

  // Stimulus queues per channel and the expected output beats
  logic [DW-1:0] data_q[$];
  logic [7:0]    eop_q[$];
  logic [7:0]    flags_q[$];
  beat_t         exp_q[$];

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  int exp_bytes = 0;
  int exp_drops = 0;
  bit exp_proto = 1'b0;

  bit nogap = 1'b0;
  bit flags_gate = 1'b1;
  int rdy_mode = 1;
  bit data_busy = 1'b0;
  bit eop_busy = 1'b0;
  bit flags_busy = 1'b0;
  int data_hs = 0;
  int flags_hs = 0;
  bit data_to = 1'b0;
  bit eop_to = 1'b0;
  bit flags_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: a packet becomes channel beats and expected output beats
  task automatic push_packet(input logic [7:0] flags, input int nbeats,
                             input logic [7:0] last_eop, input logic [DW-1:0] d0);
    bit drop;
    drop = 1'b0;
`ifdef PKTUNIT_DROP_ERR_EN
    drop = flags[0];
`endif
    flags_q.push_back(flags);
    for (int b = 0; b < nbeats; b++) begin
      logic [DW-1:0] d;
      logic [7:0]    e;
      beat_t         x;
      int            n;
      d = (b == 0) ? d0 : {$urandom, $urandom};
      e = (b == nbeats - 1) ? last_eop : 8'd0;
      n = (e == 8'd0 || e > 8'd8) ? 8 : int'(e);
      x.data = d;
      x.keep = 8'((16'h1 << n) - 16'h1);
      x.last = (e != 8'd0);
      x.user = flags;
      data_q.push_back(d);
      eop_q.push_back(e);
      if (e > 8'd8) exp_proto = 1'b1;
      if (!drop) begin
        exp_q.push_back(x);
        exp_bytes += n;
      end
    end
    if (drop) exp_drops++;
    else exp_pkts++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
    chk({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(exp_bytes));
    chk({tag, "_proto_err"}, 64'(proto_err), 64'(exp_proto));
`ifdef PKTUNIT_DROP_ERR_EN
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drops));
`endif
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tdata"}, 64'(m_tdata), 64'd0);
    chk({tag, "_tkeep"}, 64'(m_tkeep), 64'd0);
    chk({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_tuser"}, 64'(m_tuser), 64'd0);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
    chk({tag, "_byte_cnt"}, 64'(byte_cnt), 64'd0);
    chk({tag, "_proto_err"}, 64'(proto_err), 64'd0);
    chk({tag, "_readies"}, 64'({data_r, eop_r, flags_r}), 64'd0);
`ifdef PKTUNIT_DROP_ERR_EN
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
`endif
  endtask

  function automatic bit drivers_idle();
    return data_q.size() == 0 && eop_q.size() == 0 && flags_q.size() == 0 &&
           !data_busy && !eop_busy && !flags_busy;
  endfunction

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (guard < 4000 && !(drivers_idle() && exp_q.size() == 0 && !m_tvalid)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    @(posedge clk);
    #2;
  endtask

  // Data channel driver
  initial begin : drv_data
    logic [DW-1:0] item;
    int gap, guard;
    bit hs;
    data_v = 1'b0;
    data_d = '0;
    forever begin
      if (data_q.size() == 0) begin
        @(posedge clk); #1;
      end else begin
        item = data_q.pop_front();
        data_busy = 1'b1;
        gap = nogap ? 0 : int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk); #1; end
        data_v = 1'b1;
        data_d = item;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 5000) begin
          @(negedge clk); hs = data_r;
          @(posedge clk); #1;
          guard++;
        end
        if (!hs) data_to = 1'b1;
        else data_hs++;
        data_v = 1'b0;
        data_busy = 1'b0;
      end
    end
  end

  // Eop channel driver
  initial begin : drv_eop
    logic [7:0] item;
    int gap, guard;
    bit hs;
    eop_v = 1'b0;
    eop_d = '0;
    forever begin
      if (eop_q.size() == 0) begin
        @(posedge clk); #1;
      end else begin
        item = eop_q.pop_front();
        eop_busy = 1'b1;
        gap = nogap ? 0 : int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk); #1; end
        eop_v = 1'b1;
        eop_d = item;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 5000) begin
          @(negedge clk); hs = eop_r;
          @(posedge clk); #1;
          guard++;
        end
        if (!hs) eop_to = 1'b1;
        eop_v = 1'b0;
        eop_busy = 1'b0;
      end
    end
  end

  // Flags channel driver, can be held back to skew it against data/eop
  initial begin : drv_flags
    logic [7:0] item;
    int gap, guard;
    bit hs;
    flags_v = 1'b0;
    flags_d = '0;
    forever begin
      if (flags_q.size() == 0 || !flags_gate) begin
        @(posedge clk); #1;
      end else begin
        item = flags_q.pop_front();
        flags_busy = 1'b1;
        gap = nogap ? 0 : int'($urandom_range(0, 2));
        repeat (gap) begin @(posedge clk); #1; end
        flags_v = 1'b1;
        flags_d = item;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 5000) begin
          @(negedge clk); hs = flags_r;
          @(posedge clk); #1;
          guard++;
        end
        if (!hs) flags_to = 1'b1;
        else flags_hs++;
        flags_v = 1'b0;
        flags_busy = 1'b0;
      end
    end
  end

  // Output ready: 0 = random, 1 = always ready, 2 = stalled
  initial begin : drv_ready
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = ($urandom_range(0, 3) != 0);
        1:       m_tready = 1'b1;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability and joint-ready rules
  initial begin : mon
    bit    st_v;
    beat_t st;
    beat_t e;
    st_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st_v = 1'b0;
      end else begin
        if (st_v) begin
          checks++;
          if (!m_tvalid || m_tdata !== st.data || m_tkeep !== st.keep ||
              m_tlast !== st.last || m_tuser !== st.user) begin
            errors++;
            $display("FAIL hold_stable: tvalid=%0b data=%h keep=%h last=%0b user=%h, required tvalid=1 data=%h keep=%h last=%0b user=%h",
                     m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, st.data, st.keep, st.last, st.user);
          end
        end
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: data=%h keep=%h, required no beat", m_tdata, m_tkeep);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last || m_tuser !== e.user) begin
              errors++;
              $display("FAIL beat: data=%h keep=%h last=%0b user=%h, required data=%h keep=%h last=%0b user=%h",
                       m_tdata, m_tkeep, m_tlast, m_tuser, e.data, e.keep, e.last, e.user);
            end
          end
        end
        st_v    = m_tvalid && !m_tready;
        st.data = m_tdata;
        st.keep = m_tkeep;
        st.last = m_tlast;
        st.user = m_tuser;
        if (data_r || eop_r || flags_r) begin
          checks++;
          if (data_r !== eop_r || (flags_r && !data_r) || (data_r && !(data_v && eop_v)) ||
              (flags_r && !flags_v)) begin
            errors++;
            $display("FAIL ready_join: data_r=%0b eop_r=%0b flags_r=%0b, required joint readies with valids %0b%0b%0b",
                     data_r, eop_r, flags_r, data_v, eop_v, flags_v);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int fh0, dh0, guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single-beat packet
    push_packet(8'h00, 1, 8'd3, 64'h0807060504030201);
    wait_drain();
    check_counters("single");

    // Three-beat packet, flags consumed once
    fh0 = flags_hs;
    push_packet(8'h02, 3, 8'd8, {$urandom, $urandom});
    wait_drain();
    chk("three_beat_flags_once", 64'(flags_hs - fh0), 64'd1);
    check_counters("three_beat");

    // Flags arriving late must hold off the data/eop readies
    nogap = 1'b1;
    flags_gate = 1'b0;
    push_packet(8'h04, 1, 8'd8, {$urandom, $urandom});
    @(posedge clk); #2;
    repeat (3) begin
      @(negedge clk);
      chk("skew_no_ready", 64'({data_v, eop_v, data_r, eop_r, flags_r}), 64'b11000);
    end
    flags_gate = 1'b1;
    wait_drain();
    nogap = 1'b0;

    // Backpressure: only two beats fit while the output is stalled
    rdy_mode = 2;
    @(posedge clk); #2;
    nogap = 1'b1;
    dh0 = data_hs;
    push_packet(8'h10, 4, 8'd6, {$urandom, $urandom});
    repeat (6) @(posedge clk);
    #2;
    chk("bp_accepted", 64'(data_hs - dh0), 64'd2);
    @(negedge clk);
    chk("bp_ready_low", 64'({data_v, data_r}), 64'b10);
    rdy_mode = 1;
    wait_drain();
    nogap = 1'b0;
    check_counters("backpressure");

    // Randomized traffic with random output stalls
    rdy_mode = 0;
    for (int p = 0; p < 40; p++) begin
      nogap = ($urandom_range(0, 1) == 1);
      push_packet(8'($urandom), int'($urandom_range(1, 4)), 8'($urandom_range(1, 8)),
                  {$urandom, $urandom});
    end
    wait_drain();
    rdy_mode = 1;
    nogap = 1'b0;
    check_counters("random");

    // Oversize eop: full keep and sticky error
    push_packet(8'h00, 1, 8'd12, {$urandom, $urandom});
    wait_drain();
    check_counters("violation");
    wait_drain();
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // Reset in the middle of a packet
    rdy_mode = 2;
    @(posedge clk); #2;
    flags_q.push_back(8'h00);
    data_q.push_back({$urandom, $urandom});
    eop_q.push_back(8'd0);
    guard = 0;
    while (guard < 200 && !drivers_idle()) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("mid_pkt_held", 64'(m_tvalid), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    exp_pkts = 0;
    exp_bytes = 0;
    exp_drops = 0;
    exp_proto = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    rdy_mode = 1;
    nogap = 1'b1;
    flags_gate = 1'b0;
    push_packet(8'h20, 1, 8'd4, {$urandom, $urandom});
    @(posedge clk); #2;
    repeat (3) begin
      @(negedge clk);
      chk("resop_needs_flags", 64'({data_v, eop_v, data_r, eop_r, flags_r}), 64'b11000);
    end
    flags_gate = 1'b1;
    wait_drain();
    nogap = 1'b0;
    check_counters("after_reset");

`ifdef PKTUNIT_DROP_ERR_EN
    // Errored packet is swallowed, the following clean one forwarded
    push_packet(8'h01, 2, 8'd5, {$urandom, $urandom});
    push_packet(8'h00, 1, 8'd8, {$urandom, $urandom});
    wait_drain();
    check_counters("drop");
`endif

    chk("driver_timeouts", 64'({data_to, eop_to, flags_to}), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
